// File: rtl/synth_pkg.sv
// synth_pkg: shared types, note table and helpers for poly_tone_synth.
package synth_pkg;

    localparam int SYS_FREQ  = 100_000_000;
    localparam int NOTE_HP_W = 24;
    localparam int NOTES     = 36;

    typedef struct packed {
        logic [3:0]           voice;
        logic [NOTE_HP_W-1:0] half_period;
    } voice_cfg_t;

    typedef logic [NOTES-1:0][NOTE_HP_W-1:0] note_table_t;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Frequency is given in centihertz so semitone tuning stays exact in integers.
    function automatic logic [NOTE_HP_W-1:0] hp_of_freq(input int unsigned freq_chz);
        return NOTE_HP_W'((longint'(SYS_FREQ) * 50) / longint'(freq_chz));
    endfunction

    function automatic int unsigned octave3_chz(input int semi);
        case (semi)
            0:       return 13081;
            1:       return 13859;
            2:       return 14683;
            3:       return 15556;
            4:       return 16481;
            5:       return 17461;
            6:       return 18500;
            7:       return 19600;
            8:       return 20765;
            9:       return 22000;
            10:      return 23308;
            default: return 24694;
        endcase
    endfunction

    function automatic note_table_t build_note_table();
        note_table_t t;
        for (int n = 0; n < NOTES; n++) t[n] = hp_of_freq(octave3_chz(n % 12) << (n / 12));
        return t;
    endfunction

    // Index 0 = C3 ... index 35 = B5.
    localparam note_table_t NOTE_HALF_PERIOD = build_note_table();

endpackage

// File: rtl/synth_voice.sv
// synth_voice: one square-wave voice with half-period counter and apply port.
module synth_voice #(
    parameter int HP_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            apply_i,
    input  logic [HP_W-1:0] apply_hp_i,
    output logic            sq_o,
    output logic            active_o,
    output logic            wrap_o
);

    logic [HP_W-1:0] hp_q, hp_d, cnt_q, cnt_d;
    logic            sq_q, sq_d;

    assign active_o = |hp_q;
    assign wrap_o   = active_o && cnt_q == hp_q - HP_W'(1);
    assign sq_o     = sq_q;

    // A nonzero apply on a sounding voice only arrives at its wrap, so it toggles.
    always_comb begin
        hp_d  = hp_q;
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (apply_i) begin
            hp_d  = apply_hp_i;
            cnt_d = '0;
            sq_d  = |apply_hp_i && (!active_o || !sq_q);
        end else if (wrap_o) begin
            cnt_d = '0;
            sq_d  = !sq_q;
        end else if (active_o) begin
            cnt_d = cnt_q + HP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q  <= '0;
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            hp_q  <= hp_d;
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

endmodule

// File: rtl/poly_tone_synth.sv
// poly_tone_synth: VOICES square-wave voices mixed into one PWM stream.
// Optional POLY_SYNTH_AUTO_SD_EN gates the amplifier off after a silent interval.
module poly_tone_synth
    import synth_pkg::*;
#(
    parameter int VOICES         = 4,
    parameter int HP_W           = 24,
    parameter int PWM_BITS       = 8,
    parameter int SD_IDLE_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [idx_w(VOICES)-1:0]  cfg_voice,
    input  logic [HP_W-1:0]           cfg_half_period,
    output logic [VOICES-1:0]         voice_active,
    output logic                      audio_pwm,
    output logic                      audio_sd
);

    localparam int VW = idx_w(VOICES);
    localparam int LW = $clog2(VOICES + 1);
    localparam int CW = PWM_BITS + LW;

    logic [VOICES-1:0]   sq, active, wrap, apply;
    logic                rdy_q, pend_q, pend_d, clear;
    logic [VW-1:0]       pend_voice_q, pend_voice_d;
    logic [HP_W-1:0]     pend_hp_q, pend_hp_d;
    logic [LW-1:0]       level, level_q, level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_q, pwm_d;

    assign cfg_ready    = rdy_q && !pend_q;
    assign voice_active = active;
    assign audio_pwm    = pwm_q;

    for (genvar i = 0; i < VOICES; i++) begin : g_voice
        assign apply[i] = pend_q && pend_voice_q == VW'(i)
                        && (!active[i] || pend_hp_q == '0 || wrap[i]);
        synth_voice #(.HP_W(HP_W)) u_voice (
            .clk        (clk),
            .rst        (sys_rst),
            .apply_i    (apply[i]),
            .apply_hp_i (pend_hp_q),
            .sq_o       (sq[i]),
            .active_o   (active[i]),
            .wrap_o     (wrap[i])
        );
    end

    // Out-of-range targets match no voice and are simply dropped.
    assign clear = pend_q && (int'(pend_voice_q) >= VOICES || |apply);

    always_comb begin
        pend_d       = pend_q && !clear;
        pend_voice_d = pend_voice_q;
        pend_hp_d    = pend_hp_q;
        if (cfg_valid && cfg_ready) begin
            pend_d       = 1'b1;
            pend_voice_d = cfg_voice;
            pend_hp_d    = cfg_half_period;
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < VOICES; i++) level = level + LW'(sq[i]);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        level_d   = &pwm_cnt_q ? level : level_q;
        pwm_d     = {level_q, {PWM_BITS{1'b0}}} > CW'(pwm_cnt_q) * CW'(VOICES);
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            rdy_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_voice_q <= '0;
            pend_hp_q    <= '0;
            pwm_cnt_q    <= '0;
            level_q      <= '0;
            pwm_q        <= 1'b0;
        end else begin
            rdy_q        <= 1'b1;
            pend_q       <= pend_d;
            pend_voice_q <= pend_voice_d;
            pend_hp_q    <= pend_hp_d;
            pwm_cnt_q    <= pwm_cnt_d;
            level_q      <= level_d;
            pwm_q        <= pwm_d;
        end
    end

`ifdef POLY_SYNTH_AUTO_SD_EN
    localparam int IW = $clog2(SD_IDLE_CYCLES + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          sd_q, sd_d;

    // The idle count saturates so the amplifier stays off until a voice sounds.
    always_comb begin
        idle_d = |active ? '0 : (idle_q == IW'(SD_IDLE_CYCLES) ? idle_q : idle_q + IW'(1));
        sd_d   = |active || (sd_q && idle_d != IW'(SD_IDLE_CYCLES));
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            idle_q <= '0;
            sd_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            sd_q   <= sd_d;
        end
    end

    assign audio_sd = sd_q;
`else
    assign audio_sd = 1'b1;
`endif

endmodule

// File: tb/tb_poly_tone_synth.sv
// tb_poly_tone_synth: directed checks of voices, retune handshake, mixer and reset.
module tb_poly_tone_synth;

    localparam int VOICES = 3;
    localparam int HP_W   = 24;
`ifdef POLY_SYNTH_AUTO_SD_EN
    localparam logic SD_RST = 1'b0;
`else
    localparam logic SD_RST = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [1:0]        cfg_voice = '0;
    logic [HP_W-1:0]   cfg_half_period = '0;
    logic              cfg_ready, audio_pwm, audio_sd;
    logic [VOICES-1:0] voice_active;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    poly_tone_synth #(
        .VOICES(VOICES), .HP_W(HP_W), .PWM_BITS(8), .SD_IDLE_CYCLES(50)
    ) dut (
        .clk             (clk),
        .sys_rst         (sys_rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_voice       (cfg_voice),
        .cfg_half_period (cfg_half_period),
        .voice_active    (voice_active),
        .audio_pwm       (audio_pwm),
        .audio_sd        (audio_sd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the transfer edge.
    task automatic send(input int v, input int hp);
        int n = 0;
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout got=%b exp=1", cfg_ready);
        end
        cfg_voice = 2'(v);
        cfg_half_period = HP_W'(hp);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic frame_highs(output int h);
        h = 0;
        repeat (256) begin
            h += int'(audio_pwm);
            tick();
        end
    endtask

    task automatic test_reset();
        int highs = 0, act = 0;
        sys_rst = 1'b1;
        repeat (3) tick();
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cfg_ready); end
        checks++; if (voice_active !== 3'b000) begin failures++; $display("FAIL rst_active got=%b exp=000", voice_active); end
        checks++; if (audio_pwm !== 1'b0) begin failures++; $display("FAIL rst_pwm got=%b exp=0", audio_pwm); end
        checks++; if (audio_sd !== SD_RST) begin failures++; $display("FAIL rst_sd got=%b exp=%b", audio_sd, SD_RST); end
        sys_rst = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", cfg_ready); end
        repeat (1024) begin
            highs += int'(audio_pwm);
            act += int'(voice_active != 0);
            tick();
        end
        checks++; if (highs != 0) begin failures++; $display("FAIL idle_pwm got=%0d exp=0", highs); end
        checks++; if (act != 0) begin failures++; $display("FAIL idle_active got=%0d exp=0", act); end
    endtask

    task automatic test_tone();
        logic e;
        send(0, 5);
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL tone_busy got=%b exp=0", cfg_ready); end
        tick();
        checks++; if (voice_active !== 3'b001) begin failures++; $display("FAIL tone_active got=%b exp=001", voice_active); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL tone_ready got=%b exp=1", cfg_ready); end
        for (int k = 1; k <= 15; k++) begin
            e = ((k - 1) / 5) % 2 == 0;
            checks++; if (dut.sq[0] !== e) begin failures++; $display("FAIL tone_sq k=%0d got=%b exp=%b", k, dut.sq[0], e); end
            tick();
        end
        send(0, 0);
        tick();
        checks++; if (voice_active !== 3'b000) begin failures++; $display("FAIL tone_off got=%b exp=000", voice_active); end
        checks++; if (dut.sq !== 3'b000) begin failures++; $display("FAIL tone_off_sq got=%b exp=000", dut.sq); end
    endtask

    task automatic test_duty();
        int h;
        int exp_h [3] = '{86, 171, 256};
        for (int v = 0; v < 3; v++) begin
            send(v, 100000);
            repeat (600) tick();
            frame_highs(h);
            checks++; if (h != exp_h[v]) begin failures++; $display("FAIL duty_level%0d got=%0d exp=%0d", v + 1, h, exp_h[v]); end
        end
        checks++; if (voice_active !== 3'b111) begin failures++; $display("FAIL duty_active got=%b exp=111", voice_active); end
        for (int v = 0; v < 3; v++) send(v, 0);
        repeat (600) tick();
        frame_highs(h);
        checks++; if (h != 0) begin failures++; $display("FAIL duty_silent got=%0d exp=0", h); end
    endtask

    task automatic test_retune();
        int   n = 0;
        logic hold_ok = 1'b1;
        logic e;
        send(2, 100000);
        send(0, 100);
        tick();
        checks++; if (voice_active !== 3'b101) begin failures++; $display("FAIL retune_active got=%b exp=101", voice_active); end
        repeat (30) tick();
        cfg_voice = 2'd0;
        cfg_half_period = HP_W'(7);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        while (!cfg_ready && n < 200) begin
            if (dut.sq[0] !== 1'b1 || dut.sq[2] !== 1'b1) hold_ok = 1'b0;
            tick();
            n++;
        end
        checks++; if (n != 69) begin failures++; $display("FAIL retune_stall got=%0d exp=69", n); end
        checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL retune_hold got=%b exp=1", hold_ok); end
        for (int k = 0; k < 14; k++) begin
            e = (k / 7) % 2 == 1;
            checks++; if (dut.sq[0] !== e) begin failures++; $display("FAIL retune_sq k=%0d got=%b exp=%b", k, dut.sq[0], e); end
            tick();
        end
        checks++; if (dut.sq[2] !== 1'b1) begin failures++; $display("FAIL retune_other got=%b exp=1", dut.sq[2]); end
        send(0, 0);
        send(2, 0);
        tick();
        checks++; if (voice_active !== 3'b000) begin failures++; $display("FAIL retune_off got=%b exp=000", voice_active); end
    endtask

    task automatic test_out_of_range();
        int bad = 0;
        send(3, 50);
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL oor_busy got=%b exp=0", cfg_ready); end
        tick();
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", cfg_ready); end
        repeat (5) begin
            bad += int'(voice_active != 0 || dut.sq != 0);
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL oor_voices got=%0d exp=0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        send(1, 4);
        send(2, 4);
        tick();
        checks++; if (voice_active !== 3'b110) begin failures++; $display("FAIL b2b_active got=%b exp=110", voice_active); end
        for (int m = 0; m < 8; m++) begin
            e = {((m / 4) % 2 == 0), (((m + 2) / 4) % 2 == 0), 1'b0};
            checks++; if (dut.sq !== e) begin failures++; $display("FAIL b2b_sq m=%0d got=%b exp=%b", m, dut.sq, e); end
            tick();
        end
        send(1, 0);
        send(2, 0);
        tick();
        checks++; if (voice_active !== 3'b000) begin failures++; $display("FAIL b2b_off got=%b exp=000", voice_active); end
    endtask

    task automatic test_auto_sd();
`ifdef POLY_SYNTH_AUTO_SD_EN
        int n = 0;
        send(1, 10);
        tick();
        tick();
        checks++; if (audio_sd !== 1'b1) begin failures++; $display("FAIL sd_wake got=%b exp=1", audio_sd); end
        send(1, 0);
        tick();
        while (audio_sd && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n != 50) begin failures++; $display("FAIL sd_idle got=%0d exp=50", n); end
`else
        checks++; if (audio_sd !== 1'b1) begin failures++; $display("FAIL sd_const got=%b exp=1", audio_sd); end
`endif
    endtask

    task automatic test_reset_midtone();
        int n = 0;
        send(0, 100000);
        while (!audio_pwm && n < 700) begin
            tick();
            n++;
        end
        checks++; if (audio_pwm !== 1'b1) begin failures++; $display("FAIL mid_pwm_high got=%b exp=1", audio_pwm); end
        #2 sys_rst = 1'b1;
        #1;
        checks++; if (voice_active !== 3'b000) begin failures++; $display("FAIL mid_active got=%b exp=000", voice_active); end
        checks++; if (audio_pwm !== 1'b0) begin failures++; $display("FAIL mid_pwm got=%b exp=0", audio_pwm); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", cfg_ready); end
        checks++; if (audio_sd !== SD_RST) begin failures++; $display("FAIL mid_sd got=%b exp=%b", audio_sd, SD_RST); end
        tick();
        sys_rst = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_rel_ready got=%b exp=1", cfg_ready); end
        checks++; if (dut.sq !== 3'b000) begin failures++; $display("FAIL mid_rel_sq got=%b exp=000", dut.sq); end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_duty();
        test_retune();
        test_out_of_range();
        test_back_to_back();
        test_auto_sd();
        test_reset_midtone();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
